// File: rtl/stream_serializer_pkg.sv
// Shared helpers for the stream width converters (serializer now, packer later).
package stream_serializer_pkg;

  // Counter width able to index n beats; never narrower than one bit.
  function automatic int beat_cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_serializer_if.sv
// Wide-in / narrow-out valid-ready stream bundle for the serializer.
// slave is the serializer's view, master is the producer/consumer side.
interface stream_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BEATS  = 4
);
  logic [DATA_WIDTH*NUM_BEATS-1:0] data_in;
  logic                            valid_in;
  logic                            ready_in;
  logic [DATA_WIDTH-1:0]           data_out;
  logic                            valid_out;
  logic                            last_out;
  logic                            ready_out;

  modport slave (
    input  data_in, valid_in, ready_out,
    output ready_in, data_out, valid_out, last_out
  );

  modport master (
    output data_in, valid_in, ready_out,
    input  ready_in, data_out, valid_out, last_out
  );
endinterface

// File: rtl/stream_serializer_register_slice.sv
// Plain resettable register used for every state element of the serializer.
module register_slice #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Synchronous reset to RESET_VALUE, otherwise load next value every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/stream_serializer.sv
// Valid/ready width down-converter: one wide word in, NUM_BEATS narrow beats out,
// lane 0 first. Outputs are registered; consecutive words stream with no bubble.
//
//   state | meaning
//   IDLE  | no word held, ready for a new word
//   SEND  | word held, beat beat_cnt presented on data_out
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BEATS  = 4
) (
  input logic               clk,
  input logic               rst,
  stream_serializer_if.slave bus
);

  localparam int CW = beat_cnt_width(NUM_BEATS);
  localparam int WW = DATA_WIDTH * NUM_BEATS;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  state_q_raw;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [WW-1:0]         word_q, word_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  last_out_q, last_out_d;

  logic                  insert;
  logic                  remove;
  logic [CW-1:0]         next_idx;
  logic [DATA_WIDTH-1:0] next_lane;

  assign state_q = state_t'(state_q_raw);

  // A new word can enter when empty, or in the same cycle the final beat leaves.
  assign bus.ready_in = (state_q == IDLE) || ((state_q == SEND) && last_out_q && bus.ready_out);

  assign insert   = bus.valid_in & bus.ready_in;
  assign remove   = valid_out_q & bus.ready_out;
  assign next_idx = beat_cnt_q + CW'(1);

  // Lane mux for the beat that follows the one currently presented.
  always_comb begin
    next_lane = '0;
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (next_idx == CW'(k)) begin
        next_lane = word_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic; every register holds unless a handshake moves it.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    word_d      = word_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;

    case (state_q)
      IDLE: begin
        if (insert) begin
          state_d     = SEND;
          word_d      = bus.data_in;
          data_out_d  = bus.data_in[DATA_WIDTH-1:0];
          beat_cnt_d  = '0;
          valid_out_d = 1'b1;
          last_out_d  = (NUM_BEATS == 1);
        end
      end
      SEND: begin
        if (remove) begin
          if (!last_out_q) begin
            beat_cnt_d = next_idx;
            data_out_d = next_lane;
            last_out_d = (next_idx == CW'(NUM_BEATS - 1));
          end else if (insert) begin
            word_d      = bus.data_in;
            data_out_d  = bus.data_in[DATA_WIDTH-1:0];
            beat_cnt_d  = '0;
            valid_out_d = 1'b1;
            last_out_d  = (NUM_BEATS == 1);
          end else begin
            state_d     = IDLE;
            valid_out_d = 1'b0;
            last_out_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        valid_out_d = 1'b0;
        last_out_d  = 1'b0;
      end
    endcase
  end

  register_slice #(.WIDTH(1)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .d_i (state_d),
    .q_o (state_q_raw)
  );

  register_slice #(.WIDTH(CW)) u_beat_cnt_reg (
    .clk (clk),
    .rst (rst),
    .d_i (beat_cnt_d),
    .q_o (beat_cnt_q)
  );

  register_slice #(.WIDTH(WW)) u_word_reg (
    .clk (clk),
    .rst (rst),
    .d_i (word_d),
    .q_o (word_q)
  );

  register_slice #(.WIDTH(DATA_WIDTH)) u_data_out_reg (
    .clk (clk),
    .rst (rst),
    .d_i (data_out_d),
    .q_o (data_out_q)
  );

  register_slice #(.WIDTH(1)) u_valid_out_reg (
    .clk (clk),
    .rst (rst),
    .d_i (valid_out_d),
    .q_o (valid_out_q)
  );

  register_slice #(.WIDTH(1)) u_last_out_reg (
    .clk (clk),
    .rst (rst),
    .d_i (last_out_d),
    .q_o (last_out_q)
  );

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.last_out  = last_out_q;

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: a 4-lane byte instance and a 1-lane 16-bit instance.
// Stimulus pushes expected {last, data} beats; monitors compare whenever a beat is shown.
module tb_stream_serializer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stream_serializer_if #(.DATA_WIDTH(8),  .NUM_BEATS(4)) bus4 ();
  stream_serializer_if #(.DATA_WIDTH(16), .NUM_BEATS(1)) bus1 ();

  stream_serializer #(.DATA_WIDTH(8), .NUM_BEATS(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  stream_serializer #(.DATA_WIDTH(16), .NUM_BEATS(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [8:0]  exp4 [$];
  logic [16:0] exp1 [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor for the 4-lane instance: shown beat must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && bus4.valid_out) begin
      vectors++;
      if (exp4.size() == 0) begin
        miscompares++;
        $display("FAIL beat4_unexpected: got last=%b data=%h, expected no beat",
                 bus4.last_out, bus4.data_out);
      end else begin
        if ({bus4.last_out, bus4.data_out} !== exp4[0]) begin
          miscompares++;
          $display("FAIL beat4: got last=%b data=%h, expected last=%b data=%h",
                   bus4.last_out, bus4.data_out, exp4[0][8], exp4[0][7:0]);
        end
        if (bus4.ready_out) void'(exp4.pop_front());
      end
    end
  end

  // Monitor for the 1-lane instance.
  always @(negedge clk) begin
    if (!rst && bus1.valid_out) begin
      vectors++;
      if (exp1.size() == 0) begin
        miscompares++;
        $display("FAIL beat1_unexpected: got last=%b data=%h, expected no beat",
                 bus1.last_out, bus1.data_out);
      end else begin
        if ({bus1.last_out, bus1.data_out} !== exp1[0]) begin
          miscompares++;
          $display("FAIL beat1: got last=%b data=%h, expected last=%b data=%h",
                   bus1.last_out, bus1.data_out, exp1[0][16], exp1[0][15:0]);
        end
        if (bus1.ready_out) void'(exp1.pop_front());
      end
    end
  end

  task automatic push4(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      exp4.push_back({(k == 3), w[k*8 +: 8]});
    end
  endtask

  // Offer one word to the 4-lane instance; returns just after the accepting edge.
  task automatic put4(input logic [31:0] w);
    int n;
    n = 0;
    bus4.data_in  = w;
    bus4.valid_in = 1'b1;
    push4(w);
    @(negedge clk);
    while (!bus4.ready_in && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL put4_timeout: got ready_in=0 for 50 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    bus4.valid_in = 1'b0;
  endtask

  task automatic put1(input logic [15:0] w);
    int n;
    n = 0;
    bus1.data_in  = w;
    bus1.valid_in = 1'b1;
    exp1.push_back({1'b1, w});
    @(negedge clk);
    while (!bus1.ready_in && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL put1_timeout: got ready_in=0 for 50 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    bus1.valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp4.size() != 0 || exp1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_beats", exp4.size() + exp1.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] rdy_pat;
    logic [9:0] vo_pat;
    logic [3:0] stall_pat;

    rst            = 1'b1;
    bus4.data_in   = '0;
    bus4.valid_in  = 1'b0;
    bus4.ready_out = 1'b1;
    bus1.data_in   = '0;
    bus1.valid_in  = 1'b0;
    bus1.ready_out = 1'b1;

    // 1: reset state held while idle
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle4_valid_out", bus4.valid_out, 0);
      check("idle4_ready_in",  bus4.ready_in,  1);
      check("idle4_data_out",  bus4.data_out,  0);
      check("idle4_last_out",  bus4.last_out,  0);
      check("idle1_valid_out", bus1.valid_out, 0);
      check("idle1_ready_in",  bus1.ready_in,  1);
    end
    @(posedge clk);
    #1;

    // 2: single word, lanes in order, last only on DD
    put4(32'hDDCCBBAA);
    drain();

    // 3: two words back-to-back, no gap, ready_in only while the final beat leaves
    rdy_pat = 10'b1100010001;
    vo_pat  = 10'b0111111110;
    bus4.data_in  = 32'hA3A2A1A0;
    bus4.valid_in = 1'b1;
    push4(32'hA3A2A1A0);
    push4(32'hB3B2B1B0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("b2b_ready_in",  bus4.ready_in,  rdy_pat[c]);
      check("b2b_valid_out", bus4.valid_out, vo_pat[c]);
      @(posedge clk);
      #1;
      if (c == 0) bus4.data_in  = 32'hB3B2B1B0;
      if (c == 4) bus4.valid_in = 1'b0;
    end
    drain();

    // 4: downstream stalls mid-word
    stall_pat = 4'b1001;
    put4(32'h87654321);
    for (int i = 0; i < 16; i++) begin
      bus4.ready_out = stall_pat[i % 4];
      @(posedge clk);
      #1;
    end
    bus4.ready_out = 1'b1;
    drain();

    // 5: reset after beat BB discards the rest of the word
    put4(32'hDDCCBBAA);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_beats_left", exp4.size(), 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp4.delete();
    @(negedge clk);
    check("rst_valid_out", bus4.valid_out, 0);
    check("rst_ready_in",  bus4.ready_in,  1);
    check("rst_last_out",  bus4.last_out,  0);
    @(posedge clk);
    #1;
    put4(32'h44332211);
    drain();

    // 6: single-lane instance, two words streamed
    put1(16'h1234);
    put1(16'h5678);
    drain();

    @(negedge clk);
    check("end4_valid_out", bus4.valid_out, 0);
    check("end1_valid_out", bus1.valid_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
